// File: rtl/hull_fifo_pkg.sv
// hull_fifo_pkg: shared constants for the hull_fifo buffering primitive.
//   - FIFO storage-style encodings selected by the TYPE parameter.
//   - Per-queue storage style and log2 depth used by the AXI-Lite-to-SoftReg bridge.
package hull_fifo_pkg;

  // Storage style encodings; any other TYPE value behaves as FIFO_TYPE_REG.
  localparam int unsigned FIFO_TYPE_REG = 0;  // flop array
  localparam int unsigned FIFO_TYPE_RAM = 1;  // distributed/LUT RAM, async read

  // Bridge queue configuration. *_Depth values are log2 of the entry count (LOG_DEPTH).
  localparam int unsigned F1_AXIL_wr_addr_FIFO_Type  = FIFO_TYPE_REG;
  localparam int unsigned F1_AXIL_wr_addr_FIFO_Depth = 4;
  localparam int unsigned F1_AXIL_wr_data_FIFO_Type  = FIFO_TYPE_REG;
  localparam int unsigned F1_AXIL_wr_data_FIFO_Depth = 4;
  localparam int unsigned F1_AXIL_rd_req_FIFO_Type   = FIFO_TYPE_REG;
  localparam int unsigned F1_AXIL_rd_req_FIFO_Depth  = 4;
  localparam int unsigned F1_AXIL_rd_resp_FIFO_Type  = FIFO_TYPE_RAM;
  localparam int unsigned F1_AXIL_rd_resp_FIFO_Depth = 4;

  // True when TYPE selects RAM storage; everything else maps to the flop array.
  function automatic bit fifo_type_is_ram(input int unsigned fifo_type);
    return fifo_type == FIFO_TYPE_RAM;
  endfunction

endpackage

// File: rtl/hull_fifo_if.sv
// hull_fifo_if: enqueue/dequeue handshake bundle for hull_fifo.
//   wrreq/data  : enqueue request and payload (producer -> FIFO)
//   rdreq       : dequeue request (consumer -> FIFO)
//   full/empty  : occupancy flags (FIFO -> users)
//   q           : show-ahead head entry, zero when empty (FIFO -> consumer)
// Modports: master = the FIFO's user (producer + consumer), slave = the FIFO.
interface hull_fifo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             wrreq;
  logic [WIDTH-1:0] data;
  logic             full;
  logic [WIDTH-1:0] q;
  logic             empty;
  logic             rdreq;

  modport master (
    output wrreq,
    output data,
    output rdreq,
    input  full,
    input  q,
    input  empty
  );

  modport slave (
    input  wrreq,
    input  data,
    input  rdreq,
    output full,
    output q,
    output empty
  );
endinterface

// File: rtl/hull_fifo.sv
// hull_fifo: single-clock show-ahead (first-word-fall-through) FIFO.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset (dominates wrreq/rdreq)
//   fifo_if : slave side of hull_fifo_if (wrreq/data/rdreq in, full/empty/q out)
// Parameters: TYPE (0 flop array, 1 LUT RAM, others as 0), WIDTH, LOG_DEPTH (>= 1).
// The head entry is visible on q whenever the FIFO is non-empty; q is zero when empty.
module hull_fifo
  import hull_fifo_pkg::*;
#(
  parameter int unsigned TYPE      = 0,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  hull_fifo_if.slave  fifo_if
);

  localparam int unsigned Depth = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   CntFull = (LOG_DEPTH + 1)'(Depth);
  localparam logic [LOG_DEPTH:0]   CntOne  = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH-1:0] PtrOne  = LOG_DEPTH'(1);

  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 full, empty, enq, deq;
  logic [WIDTH-1:0]     rd_data;

  // Flags come from registered count only, never from same-cycle requests.
  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign enq   = fifo_if.wrreq && !full;
  assign deq   = fifo_if.rdreq && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale contents are masked by the empty gating on q.
  if (fifo_type_is_ram(TYPE)) begin : g_ram
    logic [WIDTH-1:0] mem [Depth];

    always_ff @(posedge clk) begin
      if (enq) begin
        mem[wr_ptr_q] <= fifo_if.data;
      end
    end

    assign rd_data = mem[rd_ptr_q];
  end else begin : g_reg
    logic [WIDTH-1:0] mem_q [Depth];
    logic [WIDTH-1:0] mem_d [Depth];

    always_comb begin
      mem_d = mem_q;
      if (enq) begin
        mem_d[wr_ptr_q] = fifo_if.data;
      end
    end

    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr_q];
  end

  assign fifo_if.full  = full;
  assign fifo_if.empty = empty;
  assign fifo_if.q     = empty ? '0 : rd_data;

endmodule

// File: tb/tb_hull_fifo.sv
// tb_hull_fifo: directed scenarios plus random traffic against a queue-based FIFO model.
module tb_hull_fifo;
  import hull_fifo_pkg::*;

  localparam int unsigned Width    = 32;
  localparam int unsigned LogDepth = 2;
  localparam int unsigned Depth    = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hull_fifo_if #(.WIDTH(Width)) fifo_if ();

  hull_fifo #(
    .TYPE      (FIFO_TYPE_REG),
    .WIDTH     (Width),
    .LOG_DEPTH (LogDepth)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .fifo_if (fifo_if.slave)
  );

  logic [Width-1:0] model_q [$];
  int unsigned      n_tests = 0;
  int unsigned      n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [Width-1:0] exp_q;
    int unsigned      n;
    n     = model_q.size();
    exp_q = (n == 0) ? '0 : model_q[0];
    check_eq({tag, "_empty"}, 64'(fifo_if.empty), 64'(n == 0));
    check_eq({tag, "_full"},  64'(fifo_if.full),  64'(n == Depth));
    check_eq({tag, "_q"},     64'(fifo_if.q),     64'(exp_q));
  endtask

  // One clock: drive requests, let the edge happen, update the model, compare 1ns later.
  task automatic step(input logic wr, input logic [Width-1:0] d, input logic rd,
                      input logic do_rst, input string tag);
    bit enq, deq;
    fifo_if.wrreq = wr;
    fifo_if.data  = d;
    fifo_if.rdreq = rd;
    rst           = do_rst;
    enq = wr && (model_q.size() < Depth);
    deq = rd && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (do_rst) begin
      model_q.delete();
    end else begin
      if (deq) void'(model_q.pop_front());
      if (enq) model_q.push_back(d);
    end
    fifo_if.wrreq = 1'b0;
    fifo_if.rdreq = 1'b0;
    rst           = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    fifo_if.wrreq = 1'b0;
    fifo_if.rdreq = 1'b0;
    fifo_if.data  = '0;
    rst           = 1'b1;

    // 1: reset, idle, read from empty
    step(1'b0, '0, 1'b0, 1'b1, "s1_rst");
    step(1'b0, '0, 1'b0, 1'b0, "s1_idle");
    check_eq("s1_q_zero", 64'(fifo_if.q), 64'h0);
    step(1'b0, '0, 1'b1, 1'b0, "s1_rd_empty");
    check_eq("s1_still_empty", 64'(fifo_if.empty), 64'h1);

    // 2: fill, overflow write ignored, drain in order
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, "s2_wr");
      if (i == 0) check_eq("s2_first_q", 64'(fifo_if.q), 64'hA0);
    end
    check_eq("s2_full", 64'(fifo_if.full), 64'h1);
    step(1'b1, 32'hFF, 1'b0, 1'b0, "s2_wr_full");
    for (int i = 0; i < 4; i++) begin
      check_eq("s2_head", 64'(fifo_if.q), 64'hA0 + 64'(i));
      step(1'b0, '0, 1'b1, 1'b0, "s2_rd");
    end
    check_eq("s2_drained", 64'(fifo_if.empty), 64'h1);

    // 3: full with simultaneous write+read: read only
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, "s3_wr");
    step(1'b1, 32'h55, 1'b1, 1'b0, "s3_both_full");
    check_eq("s3_q_after", 64'(fifo_if.q), 64'h11);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "s3_rd");

    // 4: empty with simultaneous write+read: write only, no bypass
    step(1'b1, 32'h77, 1'b1, 1'b0, "s4_both_empty");
    check_eq("s4_q", 64'(fifo_if.q), 64'h77);
    step(1'b0, '0, 1'b1, 1'b0, "s4_rd");

    // 5: steady state at two entries, pointers wrap
    step(1'b1, 32'h0FE, 1'b0, 1'b0, "s5_pre0");
    step(1'b1, 32'h0FF, 1'b0, 1'b0, "s5_pre1");
    for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, "s5_both");
    check_eq("s5_q_end", 64'(fifo_if.q), 64'h108);
    step(1'b0, '0, 1'b1, 1'b0, "s5_rd0");
    step(1'b0, '0, 1'b1, 1'b0, "s5_rd1");

    // 6: mid-operation reset discards contents and dominates wrreq
    for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0, "s6_wr");
    step(1'b1, 32'hDEAD, 1'b1, 1'b1, "s6_rst");
    check_eq("s6_empty_after_rst", 64'(fifo_if.empty), 64'h1);
    step(1'b1, 32'hBEEF, 1'b0, 1'b0, "s6_wr_beef");
    check_eq("s6_q_beef", 64'(fifo_if.q), 64'hBEEF);
    step(1'b0, '0, 1'b1, 1'b0, "s6_rd");

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
